// File: rtl/one_hot_to_binary.sv
// Registered one-hot to binary encoder with valid/ready handshakes on both
// sides. Malformed words (zero or several bits set) are flagged with the
// result, latched in a sticky flag and counted in a saturating counter.
module one_hot_to_binary #(
    parameter int ONE_HOT_W = 16,
    parameter int BIN_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 oh_valid_i,
    output logic                 oh_ready_o,
    input  logic [ONE_HOT_W-1:0] one_hot_i,
    output logic                 bin_valid_o,
    input  logic                 bin_ready_i,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 err_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    input  logic                 clr_err_i
);

    // Parameter sanity checks, evaluated at elaboration.
    generate
        if (ONE_HOT_W < 2) begin : g_bad_one_hot_w
            $error("one_hot_to_binary: ONE_HOT_W must be at least 2");
        end
        if (BIN_W < $clog2(ONE_HOT_W)) begin : g_bad_bin_w
            $error("one_hot_to_binary: BIN_W too narrow for ONE_HOT_W");
        end
        if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
            $error("one_hot_to_binary: ERR_CNT_W must be at least 1");
        end
    endgenerate

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    logic                 bin_valid_q;
    logic [BIN_W-1:0]     bin_q;
    logic                 err_q;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic [ONE_HOT_W-1:0] oh_word;
    logic [BIN_W-1:0]     enc_idx;
    logic                 enc_err;
    logic                 accept;
    logic                 err_sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    // The slot frees up when empty or being drained this cycle; no path
    // from oh_valid_i, so upstream may wait on ready before asserting valid.
    assign oh_ready_o = !bin_valid_q || bin_ready_i;
    assign accept     = oh_valid_i && oh_ready_o;

    // Unqualified input data is forced to zero so X never reaches state.
    assign oh_word = oh_valid_i ? one_hot_i : '0;

    // Encode: lowest set bit wins, malformed when zero or several bits set.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        enc_idx = '0;
        for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
            if (oh_word[i]) begin
                enc_idx = BIN_W'(i);
            end
        end
        enc_err = (oh_word == '0) ||
                  ((oh_word & (oh_word - ONE_HOT_W'(1))) != '0);
    end

    // Error accounting at accept time: clear first, then add the new error.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (clr_err_i) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
        if (accept && enc_err) begin
            err_sticky_d = 1'b1;
            if (err_cnt_d != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
        end
    end

    // Single pipeline register: load on accept, drop valid on a bare consume.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is written with <= so every flop samples pre-edge
        // values regardless of statement order.
        if (!reset_n) begin
            bin_valid_q  <= 1'b0;
            bin_q        <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            if (accept) begin
                bin_valid_q <= 1'b1;
                bin_q       <= enc_idx;
                err_q       <= enc_err;
            end else if (bin_ready_i) begin
                bin_valid_q <= 1'b0;
            end
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bin_valid_o  = bin_valid_q;
    assign bin_o        = bin_q;
    assign err_o        = err_q;
    assign err_sticky_o = err_sticky_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_one_hot_to_binary.sv
// Directed and randomised checks of the registered one-hot to binary encoder.
module tb_one_hot_to_binary;

    localparam int ONE_HOT_W = 16;
    localparam int BIN_W     = 4;
    localparam int ERR_CNT_W = 2;

    logic                 clk;
    logic                 reset_n;
    logic                 oh_valid_i;
    logic                 oh_ready_o;
    logic [ONE_HOT_W-1:0] one_hot_i;
    logic                 bin_valid_o;
    logic                 bin_ready_i;
    logic [BIN_W-1:0]     bin_o;
    logic                 err_o;
    logic                 err_sticky_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
    logic                 clr_err_i;

    int checks = 0;
    int errors = 0;

    // Scoreboard / reference state for the random phase.
    logic [4:0]           exp_q[$];
    logic                 m_valid;
    logic                 m_sticky;
    logic [ERR_CNT_W-1:0] m_cnt;

    one_hot_to_binary #(
        .ONE_HOT_W(ONE_HOT_W),
        .BIN_W    (BIN_W),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .oh_valid_i  (oh_valid_i),
        .oh_ready_o  (oh_ready_o),
        .one_hot_i   (one_hot_i),
        .bin_valid_o (bin_valid_o),
        .bin_ready_i (bin_ready_i),
        .bin_o       (bin_o),
        .err_o       (err_o),
        .err_sticky_o(err_sticky_o),
        .err_cnt_o   (err_cnt_o),
        .clr_err_i   (clr_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ONE_HOT_W-1:0] w, input logic r, input logic c);
        oh_valid_i  = v;
        one_hot_i   = w;
        bin_ready_i = r;
        clr_err_i   = c;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [BIN_W-1:0] b, input logic e);
        check({tag, ".valid"}, 32'(bin_valid_o), 32'(v));
        check({tag, ".bin"},   32'(bin_o),       32'(b));
        check({tag, ".err"},   32'(err_o),       32'(e));
    endtask

    task automatic check_errs(input string tag, input logic s, input logic [ERR_CNT_W-1:0] c);
        check({tag, ".sticky"}, 32'(err_sticky_o), 32'(s));
        check({tag, ".cnt"},    32'(err_cnt_o),    32'(c));
    endtask

    // Reference encoder: popcount for validity, upward scan for lowest bit.
    function automatic logic [4:0] ref_encode(input logic [ONE_HOT_W-1:0] w);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < ONE_HOT_W; i++) begin
            if (!found && w[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return {($countones(w) != 1), idx};
    endfunction

    // One random-phase cycle: inputs already driven at edge+1.
    task automatic model_cycle();
        logic       m_ready;
        logic       acc;
        logic [4:0] got;
        logic [4:0] r;
        #1;
        m_ready = !m_valid || bin_ready_i;
        check("rnd.oh_ready",  32'(oh_ready_o),  32'(m_ready));
        check("rnd.bin_valid", 32'(bin_valid_o), 32'(m_valid));
        if (m_valid && bin_ready_i) begin
            got = {err_o, bin_o};
            if (exp_q.size() == 0) begin
                check("rnd.unexpected_result", 32'(got), 32'h1f_ffff);
            end else begin
                check("rnd.result", 32'(got), 32'(exp_q.pop_front()));
            end
        end
        acc = oh_valid_i && m_ready;
        r   = ref_encode(one_hot_i);
        if (acc) exp_q.push_back(r);
        m_valid = acc || (m_valid && !bin_ready_i);
        if (clr_err_i) begin
            m_cnt    = '0;
            m_sticky = 1'b0;
        end
        if (acc && r[4]) begin
            m_sticky = 1'b1;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        tick();
        check("rnd.sticky", 32'(err_sticky_o), 32'(m_sticky));
        check("rnd.cnt",    32'(err_cnt_o),    32'(m_cnt));
    endtask

    initial begin
        logic [ONE_HOT_W-1:0] w;
        logic [2:0] exp_cnt [5];
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};

        reset_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #10;
        check_out("reset", 1'b0, 4'd0, 1'b0);
        check_errs("reset", 1'b0, 2'd0);
        check("reset.oh_ready", 32'(oh_ready_o), 32'd1);
        #6 reset_n = 1'b1;
        tick();

        // Back-to-back valid one-hot words.
        drive(1'b1, 16'h0001, 1'b1, 1'b0);
        #1 check("b2b.ready0", 32'(oh_ready_o), 32'd1);
        tick();
        check_out("b2b.w0", 1'b1, 4'd0, 1'b0);
        drive(1'b1, 16'h0100, 1'b1, 1'b0);
        #1 check("b2b.ready1", 32'(oh_ready_o), 32'd1);
        tick();
        check_out("b2b.w1", 1'b1, 4'd8, 1'b0);
        drive(1'b1, 16'h8000, 1'b1, 1'b0);
        #1 check("b2b.ready2", 32'(oh_ready_o), 32'd1);
        tick();
        check_out("b2b.w2", 1'b1, 4'd15, 1'b0);
        drive(1'b0, 16'hxxxx, 1'b1, 1'b0);
        tick();
        check_out("b2b.drain", 1'b0, 4'd15, 1'b0);
        check_errs("b2b.x_ignored", 1'b0, 2'd0);

        // Malformed words: none set, then several set.
        drive(1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        check_out("bad.zero", 1'b1, 4'd0, 1'b1);
        check_errs("bad.zero", 1'b1, 2'd1);
        drive(1'b1, 16'h0014, 1'b1, 1'b0);
        tick();
        check_out("bad.multi", 1'b1, 4'd2, 1'b1);
        check_errs("bad.multi", 1'b1, 2'd2);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // Stall: held result stays put, pending word not taken.
        drive(1'b1, 16'h0040, 1'b1, 1'b0);
        tick();
        check_out("stall.load", 1'b1, 4'd6, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 check("stall.ready", 32'(oh_ready_o), 32'd0);
            tick();
            check_out("stall.hold", 1'b1, 4'd6, 1'b0);
        end
        bin_ready_i = 1'b1;
        #1 check("stall.release_ready", 32'(oh_ready_o), 32'd1);
        tick();
        check_out("stall.next", 1'b1, 4'd1, 1'b0);
        check_errs("stall.errs", 1'b1, 2'd2);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // Clear alone, then saturation, then clear with a new error.
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        check_errs("clr.alone", 1'b0, 2'd0);
        check("clr.alone.valid", 32'(bin_valid_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0003, 1'b1, 1'b0);
            tick();
            check_out("sat.word", 1'b1, 4'd0, 1'b1);
            check("sat.cnt", 32'(err_cnt_o), 32'(exp_cnt[i]));
        end
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        check_errs("clr.after_sat", 1'b0, 2'd0);
        drive(1'b1, 16'h0000, 1'b1, 1'b1);
        tick();
        check_errs("clr.with_err", 1'b1, 2'd1);
        check_out("clr.with_err", 1'b1, 4'd0, 1'b1);

        // Asynchronous reset while holding a result with a saturated count.
        drive(1'b1, 16'h0003, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0003, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check_errs("arst.pre", 1'b1, 2'd3);
        check("arst.pre.valid", 32'(bin_valid_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_out("arst.now", 1'b0, 4'd0, 1'b0);
        check_errs("arst.now", 1'b0, 2'd0);
        check("arst.now.ready", 32'(oh_ready_o), 32'd1);
        #3 reset_n = 1'b1;
        tick();
        drive(1'b1, 16'h0400, 1'b1, 1'b0);
        tick();
        check_out("arst.after", 1'b1, 4'd10, 1'b0);
        check_errs("arst.after", 1'b0, 2'd0);

        // Random traffic against the reference model and scoreboard.
        exp_q.push_back({1'b0, 4'd10});
        m_valid  = 1'b1;
        m_sticky = 1'b0;
        m_cnt    = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1) == 1) w = 16'(1) << $urandom_range(15);
            else if ($urandom_range(7) == 0) w = '0;
            else w = 16'($urandom);
            drive($urandom_range(3) != 0, w, $urandom_range(2) != 0, $urandom_range(15) == 0);
            model_cycle();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        model_cycle();
        model_cycle();
        check("rnd.drained_queue", 32'(exp_q.size()), 32'd0);
        check("rnd.drained_valid", 32'(bin_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/one_hot_to_binary.md
Name: one_hot_to_binary

Overview:
- Registered one-hot to binary encoder. It is the decode-side counterpart of the team's binary-to-one-hot converter.
- Takes one-hot words over a valid/ready handshake and returns the bit index over a second valid/ready handshake.
- Flags malformed codes and counts them for debug.
- Placed wherever one-hot grant or select vectors must be turned back into indices, e.g. arbiter grant to ID, or FSM state to debug bus.

Parameters:
- ONE_HOT_W, 16, width of the one-hot input word. Must be at least 2.
- BIN_W, 4, width of the binary output. Must satisfy BIN_W >= clog2(ONE_HOT_W); elaboration error otherwise.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- oh_valid_i  input  1  one_hot_i holds a valid word.
- oh_ready_o  output  1  block can accept a word this cycle.
- one_hot_i  input  ONE_HOT_W  one-hot word to encode.
- bin_valid_o  output  1  bin_o and err_o hold a valid result.
- bin_ready_i  input  1  downstream takes the result this cycle.
- bin_o  output  BIN_W  encoded index.
- err_o  output  1  the word behind the current result was not exactly one-hot.
- err_sticky_o  output  1  set by any accepted malformed word; held until cleared.
- err_cnt_o  output  ERR_CNT_W  number of accepted malformed words, saturating.
- clr_err_i  input  1  synchronous clear of err_sticky_o and err_cnt_o.

Behaviour:
- Reset, asynchronous on reset_n low: bin_valid_o=0, bin_o=0, err_o=0, err_sticky_o=0, err_cnt_o=0.
  - Reset mid-transfer discards the held result.
  - oh_ready_o=1 during reset and after release.
- Structure: one pipeline register stage, no internal FIFO.
- Ready rule: oh_ready_o = !bin_valid_o || bin_ready_i. It is combinational from bin_ready_i; there is no combinational path from oh_valid_i.
- Accept: a word is accepted when oh_valid_i && oh_ready_o. Its result appears on bin_o/err_o with bin_valid_o=1 on the next cycle, so latency is 1 cycle.
  - Back-to-back accepts sustain 1 word per cycle while bin_ready_i=1.
- Output side:
  - When bin_valid_o && bin_ready_i and no new accept in that cycle, bin_valid_o goes to 0 next cycle.
  - bin_o and err_o keep their last values when not valid.
  - Consume and accept in the same cycle: the register loads the new result and bin_valid_o stays 1.
- Stall: while bin_valid_o=1 and bin_ready_i=0, bin_o, err_o and bin_valid_o hold stable, and oh_ready_o=0.
- Encoding rules:
  - Exactly one bit set at position k: bin_o=k, err_o=0.
  - Zero bits set: bin_o=0, err_o=1.
  - Two or more bits set: bin_o = index of the lowest set bit, err_o=1.
  - Indices are zero-extended to BIN_W.
- Error accounting happens at accept time, not at output time.
  - Each accepted malformed word sets err_sticky_o on the next cycle.
  - It also increments err_cnt_o by 1, saturating at 2^ERR_CNT_W-1 with no wrap.
- clr_err_i: err_sticky_o and err_cnt_o become 0 next cycle.
  - clr_err_i has no effect on bin_o, err_o or the handshake.
  - clr_err_i in the same cycle as an accepted malformed word: clear is applied first, then the new error, giving err_cnt_o=1 and err_sticky_o=1.
- Not qualified: oh_valid_i=0 ignores one_hot_i entirely; X on it must not reach any state.

Test Plan:
- ONE_HOT_W=16. Accept 0x0001, 0x0100 and 0x8000 back-to-back with bin_ready_i=1 -> bin_o = 0, 8, 15 on consecutive cycles, each 1 cycle after its accept, err_o=0, oh_ready_o constantly 1.
- Accept 0x0000, then 0x0014 -> results bin_o=0/err_o=1, then bin_o=2/err_o=1; err_cnt_o=2, err_sticky_o=1.
- Accept 0x0040, then hold bin_ready_i=0 for 5 cycles while oh_valid_i=1 with 0x0002 -> bin_o=6 stable, oh_ready_o=0, 0x0002 not accepted. Raise bin_ready_i -> 0x0002 accepted in that cycle, bin_o=1 on the next.
- ERR_CNT_W=2. Accept 5 words of 0x0003 -> err_cnt_o counts 1, 2, 3, 3, 3. Assert clr_err_i alone -> err_cnt_o=0, err_sticky_o=0. Assert clr_err_i together with an accepted 0x0000 -> err_cnt_o=1, err_sticky_o=1.
- Drop reset_n asynchronously (not on a clock edge) while bin_valid_o=1 and err_cnt_o=3 -> all outputs 0 immediately, oh_ready_o=1. After release, accept 0x0400 -> bin_o=10 one cycle later.
- Random one-hot and non-one-hot stimulus with random bin_ready_i, checked by a scoreboard against the encoding rules -> no lost or duplicated results, and err_cnt_o equals the model count.
